// File: rtl/sopc_run_ctrl.sv
// Run controller: holds cores in reset, releases them with an optional stagger,
// runs for a cycle budget (or until halted), then parks in DONE until restarted.
module sopc_run_ctrl #(
  parameter int NUM_CH      = 1,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGGER     = 0,
  parameter int RUN_CYCLES  = 50,
  parameter int STOP_HOLD   = 1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart_i,
  input  logic              halt_req_i,
  output logic [NUM_CH-1:0] core_rst_o,
  output logic              run_o,
  output logic              done_o,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  localparam int REL_SPAN = STAGGER * (NUM_CH - 1);
  localparam int SEQ_MAX0 = (HOLD_CYCLES > REL_SPAN) ? HOLD_CYCLES : REL_SPAN;
  localparam int SEQ_MAX  = (SEQ_MAX0 > STOP_HOLD) ? SEQ_MAX0 : STOP_HOLD;
  localparam int SEQ_W    = $clog2(SEQ_MAX + 1);
  localparam bit USE_REL  = (NUM_CH > 1) && (STAGGER > 0);

  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_REL  = 3'd1,
    ST_RUN  = 3'd2,
    ST_STOP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [SEQ_W-1:0]   seq_cnt_reg, seq_cnt_next;
  logic [NUM_CH-1:0]  core_rst_reg, core_rst_next;
  logic               run_reg, run_next;
  logic               done_reg, done_next;
  logic [CNT_W-1:0]   cycle_cnt_reg, cycle_cnt_next;

  logic [SEQ_W:0]     seq_inc;
  logic [CNT_W:0]     cyc_inc;
  logic [CNT_W-1:0]   cyc_sat;
  logic               budget_hit;
  logic [NUM_CH-1:0]  rel_mask;

  // One spare bit keeps the increment from wrapping before the compare.
  assign seq_inc    = {1'b0, seq_cnt_reg} + (SEQ_W + 1)'(1);
  assign cyc_inc    = {1'b0, cycle_cnt_reg} + (CNT_W + 1)'(1);
  assign cyc_sat    = cyc_inc[CNT_W] ? cycle_cnt_reg : cyc_inc[CNT_W-1:0];
  assign budget_hit = (RUN_CYCLES != 0) && (cyc_inc == (CNT_W + 1)'(RUN_CYCLES));

  // Channel gi stays in reset until STAGGER*gi edges after channel 0 let go.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rel
    assign rel_mask[gi] = seq_inc < (SEQ_W + 1)'(STAGGER * gi);
  end

  always_comb begin
    state_next     = state_reg;
    seq_cnt_next   = seq_cnt_reg;
    core_rst_next  = core_rst_reg;
    run_next       = run_reg;
    done_next      = 1'b0;
    cycle_cnt_next = cycle_cnt_reg;

    if (restart_i) begin
      state_next     = ST_HOLD;
      seq_cnt_next   = '0;
      core_rst_next  = '1;
      run_next       = 1'b0;
      cycle_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (seq_inc == (SEQ_W + 1)'(HOLD_CYCLES)) begin
            seq_cnt_next = '0;
            if (USE_REL) begin
              state_next    = ST_REL;
              core_rst_next = ~NUM_CH'(1);
            end else begin
              state_next     = ST_RUN;
              core_rst_next  = '0;
              run_next       = 1'b1;
              cycle_cnt_next = '0;
            end
          end else begin
            seq_cnt_next = seq_inc[SEQ_W-1:0];
          end
        end
        ST_REL: begin
          core_rst_next = core_rst_reg & rel_mask;
          if (seq_inc == (SEQ_W + 1)'(REL_SPAN)) begin
            state_next     = ST_RUN;
            seq_cnt_next   = '0;
            run_next       = 1'b1;
            cycle_cnt_next = '0;
          end else begin
            seq_cnt_next = seq_inc[SEQ_W-1:0];
          end
        end
        ST_RUN: begin
          cycle_cnt_next = cyc_sat;
          if (budget_hit || halt_req_i) begin
            state_next    = ST_STOP;
            seq_cnt_next  = '0;
            core_rst_next = '1;
            run_next      = 1'b0;
          end
        end
        ST_STOP: begin
          if (seq_inc == (SEQ_W + 1)'(STOP_HOLD)) begin
            state_next   = ST_DONE;
            seq_cnt_next = '0;
            done_next    = 1'b1;
          end else begin
            seq_cnt_next = seq_inc[SEQ_W-1:0];
          end
        end
        ST_DONE: begin
          state_next = ST_DONE;
        end
        default: begin
          state_next    = ST_HOLD;
          seq_cnt_next  = '0;
          core_rst_next = '1;
          run_next      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_HOLD;
      seq_cnt_reg   <= '0;
      core_rst_reg  <= '1;
      run_reg       <= 1'b0;
      done_reg      <= 1'b0;
      cycle_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      seq_cnt_reg   <= seq_cnt_next;
      core_rst_reg  <= core_rst_next;
      run_reg       <= run_next;
      done_reg      <= done_next;
      cycle_cnt_reg <= cycle_cnt_next;
    end
  end

  assign core_rst_o  = core_rst_reg;
  assign run_o       = run_reg;
  assign done_o      = done_reg;
  assign state_o     = state_reg;
  assign cycle_cnt_o = cycle_cnt_reg;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Bench for sopc_run_ctrl: three parameterisations driven together and checked
// every edge against a timeline model (edges since sequence start, end edge).
module tb_sopc_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic restart_i = 1'b0;
  logic halt_req_i = 1'b0;

  logic [0:0]  c0;
  logic [2:0]  c1;
  logic [1:0]  c2;
  logic        r0, r1, r2, d0, d1, d2;
  logic [2:0]  s0, s1, s2;
  logic [31:0] y0, y1;
  logic [7:0]  y2;

  sopc_run_ctrl u_def (
    .clk(clk), .rst(rst), .restart_i(restart_i), .halt_req_i(halt_req_i),
    .core_rst_o(c0), .run_o(r0), .done_o(d0), .state_o(s0), .cycle_cnt_o(y0)
  );

  sopc_run_ctrl #(.NUM_CH(3), .HOLD_CYCLES(4), .STAGGER(2), .RUN_CYCLES(12), .STOP_HOLD(2)) u_stg (
    .clk(clk), .rst(rst), .restart_i(restart_i), .halt_req_i(halt_req_i),
    .core_rst_o(c1), .run_o(r1), .done_o(d1), .state_o(s1), .cycle_cnt_o(y1)
  );

  sopc_run_ctrl #(.NUM_CH(2), .HOLD_CYCLES(6), .STAGGER(0), .RUN_CYCLES(0), .STOP_HOLD(3), .CNT_W(8)) u_unb (
    .clk(clk), .rst(rst), .restart_i(restart_i), .halt_req_i(halt_req_i),
    .core_rst_o(c2), .run_o(r2), .done_o(d2), .state_o(s2), .cycle_cnt_o(y2)
  );

  localparam int     P_N   [3] = '{1, 3, 2};
  localparam int     P_H   [3] = '{10, 4, 6};
  localparam int     P_S   [3] = '{0, 2, 0};
  localparam int     P_R   [3] = '{50, 12, 0};
  localparam int     P_SH  [3] = '{1, 2, 3};
  localparam longint P_MAX [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd255};

  // Model: mt = edges since (re)start, me = edge on which RUN ended (-1 if not yet)
  longint mt [3];
  longint me [3];
  int total = 0;
  int bad = 0;

  function automatic longint run_start(int i);
    return longint'(P_H[i] + P_S[i] * (P_N[i] - 1));
  endfunction

  function automatic logic [40:0] expect_obs(int i);
    logic [2:0]  core;
    logic [2:0]  st;
    logic        run, done;
    longint      cyc;
    longint      rs;
    bit          ended;
    logic [31:0] cyc32;
    rs    = run_start(i);
    ended = (me[i] >= 0);
    core  = '0;
    for (int k = 0; k < P_N[i]; k++)
      core[k] = ended || (mt[i] < longint'(P_H[i] + P_S[i] * k));
    run  = !ended && (mt[i] >= rs);
    done = ended && (mt[i] == me[i] + P_SH[i]);
    if (mt[i] < P_H[i])               st = 3'd0;
    else if (mt[i] < rs)              st = 3'd1;
    else if (!ended)                  st = 3'd2;
    else if (mt[i] < me[i] + P_SH[i]) st = 3'd3;
    else                              st = 3'd4;
    cyc = ended ? (me[i] - rs) : ((mt[i] >= rs) ? (mt[i] - rs) : 0);
    if (cyc > P_MAX[i]) cyc = P_MAX[i];
    cyc32 = cyc[31:0];
    return {core, run, done, st, cyc32};
  endfunction

  function automatic logic [40:0] obs(int i);
    case (i)
      0:       return {2'b00, c0, r0, d0, s0, y0};
      1:       return {c1, r1, d1, s1, y1};
      default: return {1'b0, c2, r2, d2, s2, 24'd0, y2};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mt[i] = 0;
      me[i] = -1;
    end
  endtask

  // Advance one edge, update the model from the inputs sampled there, settle.
  task automatic tick();
    bit in_run;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst || restart_i) begin
        mt[i] = 0;
        me[i] = -1;
      end else begin
        in_run = (mt[i] >= run_start(i)) && (me[i] < 0);
        mt[i]++;
        if (in_run && (halt_req_i || (P_R[i] != 0 && mt[i] - run_start(i) == P_R[i])))
          me[i] = mt[i];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expect_obs(i)) begin
          bad++;
          $display("FAIL reset u%0d got=%h want=%h", i, obs(i), expect_obs(i));
        end
      end
      total++;
      if ({c1, r1, d1, s1, y1} !== {3'b111, 1'b0, 1'b0, 3'd0, 32'd0}) begin
        bad++;
        $display("FAIL reset_const got=%b_%b_%b_%0d_%0d want=111_0_0_0_0", c1, r1, d1, s1, y1);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_default_run();
    for (int e = 1; e <= 70; e++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expect_obs(i)) begin
          bad++;
          $display("FAIL default_run u%0d edge=%0d got=%h want=%h", i, e, obs(i), expect_obs(i));
        end
      end
      if (e == 9 || e == 10 || e == 60) begin
        total++;
        if (c0 !== ((e == 10) ? 1'b0 : 1'b1) || r0 !== (e == 10)) begin
          bad++;
          $display("FAIL default_edges edge=%0d got core=%b run=%b", e, c0, r0);
        end
      end
      if (e == 61) begin
        total++;
        if (d0 !== 1'b1 || y0 !== 32'd50 || s0 !== 3'd4) begin
          bad++;
          $display("FAIL default_done got done=%b cnt=%0d state=%0d want 1/50/4", d0, y0, s0);
        end
      end
      if (e == 4 || e == 6 || e == 8) begin
        total++;
        if (c1 !== ((e == 4) ? 3'b110 : (e == 6) ? 3'b100 : 3'b000) || r1 !== (e == 8)) begin
          bad++;
          $display("FAIL stagger edge=%0d got core=%b run=%b", e, c1, r1);
        end
      end
    end
  endtask

  task automatic test_halt();
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expect_obs(i)) begin
          bad++;
          $display("FAIL halt_pre u%0d edge=%0d got=%h want=%h", i, e, obs(i), expect_obs(i));
        end
      end
    end
    halt_req_i = 1'b1;
    tick();
    halt_req_i = 1'b0;
    total++;
    if (y2 !== 8'd20 || s2 !== 3'd3 || r2 !== 1'b0) begin
      bad++;
      $display("FAIL halt_stop got cnt=%0d state=%0d run=%b want 20/3/0", y2, s2, r2);
    end
    for (int e = 1; e <= 4; e++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expect_obs(i)) begin
          bad++;
          $display("FAIL halt_post u%0d edge=%0d got=%h want=%h", i, e, obs(i), expect_obs(i));
        end
      end
      total++;
      if (d2 !== (e == 3)) begin
        bad++;
        $display("FAIL halt_done edge=%0d got=%b want=%b", e, d2, (e == 3));
      end
    end
    // Unbounded budget: run must persist and the 8-bit counter must saturate.
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    for (int e = 1; e <= 1100; e++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expect_obs(i)) begin
          bad++;
          $display("FAIL unbounded u%0d edge=%0d got=%h want=%h", i, e, obs(i), expect_obs(i));
        end
      end
    end
    total++;
    if (r2 !== 1'b1 || y2 !== 8'hFF) begin
      bad++;
      $display("FAIL saturate got run=%b cnt=%0d want 1/255", r2, y2);
    end
  endtask

  task automatic test_restart();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1)
        for (int e = 0; e < 17; e++) tick();
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
      total++;
      if (c0 !== 1'b1 || y0 !== 32'd0 || s0 !== 3'd0 || r0 !== 1'b0 || c1 !== 3'b111) begin
        bad++;
        $display("FAIL restart_entry pass=%0d got core=%b cnt=%0d state=%0d run=%b", pass, c0, y0, s0, r0);
      end
    end
    for (int e = 1; e <= 70; e++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expect_obs(i)) begin
          bad++;
          $display("FAIL restart u%0d edge=%0d got=%h want=%h", i, e, obs(i), expect_obs(i));
        end
      end
      total++;
      if (d0 !== (e == 61)) begin
        bad++;
        $display("FAIL restart_done edge=%0d got=%b want=%b", e, d0, (e == 61));
      end
    end
  endtask

  task automatic test_async_reset();
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    for (int e = 0; e < 25; e++) tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs(0) !== {2'b00, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0}) begin
      bad++;
      $display("FAIL async_reset got=%h want=%h", obs(0), {2'b00, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0});
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs(i) !== expect_obs(i)) begin
        bad++;
        $display("FAIL async_reset u%0d got=%h want=%h", i, obs(i), expect_obs(i));
      end
    end
    tick();
    rst = 1'b1;
    for (int e = 1; e <= 65; e++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expect_obs(i)) begin
          bad++;
          $display("FAIL async_resume u%0d edge=%0d got=%h want=%h", i, e, obs(i), expect_obs(i));
        end
      end
    end
    total++;
    if (y0 !== 32'd50 || s0 !== 3'd4) begin
      bad++;
      $display("FAIL async_resume_final got cnt=%0d state=%0d want 50/4", y0, s0);
    end
  endtask

  task automatic test_halt_outside_run();
    restart_i  = 1'b1;
    halt_req_i = 1'b1;
    tick();
    restart_i = 1'b0;
    for (int e = 1; e <= 70; e++) begin
      halt_req_i = (e < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (e == 10) halt_req_i = 1'b1;
      tick();
      halt_req_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expect_obs(i)) begin
          bad++;
          $display("FAIL halt_outside u%0d edge=%0d got=%h want=%h", i, e, obs(i), expect_obs(i));
        end
      end
      if (e == 61) begin
        total++;
        if (d0 !== 1'b1 || y0 !== 32'd50) begin
          bad++;
          $display("FAIL halt_outside_done got done=%b cnt=%0d want 1/50", d0, y0);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int e = 1; e <= 800; e++) begin
      restart_i  = ($urandom_range(0, 149) == 0);
      halt_req_i = ($urandom_range(0, 19) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expect_obs(i)) begin
          bad++;
          $display("FAIL random u%0d edge=%0d got=%h want=%h", i, e, obs(i), expect_obs(i));
        end
      end
    end
    restart_i  = 1'b0;
    halt_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_halt();
    test_restart();
    test_async_reset();
    test_halt_outside_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
